// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter
//   Shares one SRAM-like memory port between the instruction-fetch requester
//   (read-only) and the data requester (loads/stores). One transaction is in
//   flight at a time, sequenced by an IDLE -> ADDR -> (WAIT) -> DONE FSM.
//   Simultaneous requests are resolved round-robin against the last grant.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   inst_req/inst_addr       fetch request, held until inst_done
//   inst_rdata/inst_done     fetched word (held) and one-cycle completion pulse
//   data_req/data_wen/       data request; data_wen==0 is a read
//   data_addr/data_wdata
//   data_rdata/data_done     load word (held) and one-cycle completion pulse
//   mem_req/mem_wen/         memory port command, held until mem_ack
//   mem_addr/mem_wdata
//   mem_ack                  command accepted this cycle
//   mem_rvalid/mem_rdata     read return, at least one cycle after mem_ack
//   stallreq_if/stallreq_mem pipeline stall requests while a request is open
module sram_port_arbiter #(
  parameter bit DATA_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic [31:0] inst_rdata,
  output logic        inst_done,
  input  logic        data_req,
  input  logic [3:0]  data_wen,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_done,
  output logic        mem_req,
  output logic [3:0]  mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        stallreq_if,
  output logic        stallreq_mem
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Round-robin reset value: "last grant was inst" lets data win the first tie.
  localparam logic LAST_GRANT_RST = ~DATA_FIRST;

  state_t      state_q, state_d;
  logic        owner_q, owner_d;            // 1 = data requester owns the port
  logic        last_grant_q, last_grant_d;  // 1 = data was granted last
  logic        mem_req_q, mem_req_d;
  logic [3:0]  mem_wen_q, mem_wen_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] inst_rdata_q, inst_rdata_d;
  logic [31:0] data_rdata_q, data_rdata_d;
  logic        inst_done_q, inst_done_d;
  logic        data_done_q, data_done_d;
  logic        grant_data;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    mem_req_d    = mem_req_q;
    mem_wen_d    = mem_wen_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    inst_rdata_d = inst_rdata_q;
    data_rdata_d = data_rdata_q;
    inst_done_d  = 1'b0;
    data_done_d  = 1'b0;
    // On a tie the requester opposite the previous grant wins.
    grant_data   = data_req && (!inst_req || !last_grant_q);

    case (state_q)
      S_IDLE: begin
        if (data_req || inst_req) begin
          owner_d      = grant_data;
          last_grant_d = grant_data;
          mem_req_d    = 1'b1;
          state_d      = S_ADDR;
          if (grant_data) begin
            mem_wen_d   = data_wen;
            mem_addr_d  = data_addr;
            mem_wdata_d = data_wdata;
          end else begin
            mem_wen_d   = 4'd0;
            mem_addr_d  = inst_addr;
            mem_wdata_d = 32'd0;
          end
        end
      end

      S_ADDR: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          if (mem_wen_q != 4'd0) begin
            // A write is complete once the port accepts it.
            state_d = S_DONE;
            if (owner_q) data_done_d = 1'b1;
            else         inst_done_d = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end
      end

      S_WAIT: begin
        if (mem_rvalid) begin
          state_d = S_DONE;
          if (owner_q) begin
            data_rdata_d = mem_rdata;
            data_done_d  = 1'b1;
          end else begin
            inst_rdata_d = mem_rdata;
            inst_done_d  = 1'b1;
          end
        end
      end

      S_DONE: begin
        // Done pulse is visible during this state; one idle bubble follows.
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= LAST_GRANT_RST;
      mem_req_q    <= 1'b0;
      mem_wen_q    <= 4'd0;
      mem_addr_q   <= 32'd0;
      mem_wdata_q  <= 32'd0;
      inst_rdata_q <= 32'd0;
      data_rdata_q <= 32'd0;
      inst_done_q  <= 1'b0;
      data_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      mem_req_q    <= mem_req_d;
      mem_wen_q    <= mem_wen_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
      inst_done_q  <= inst_done_d;
      data_done_q  <= data_done_d;
    end
  end

  assign mem_req      = mem_req_q;
  assign mem_wen      = mem_wen_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign inst_rdata   = inst_rdata_q;
  assign data_rdata   = data_rdata_q;
  assign inst_done    = inst_done_q;
  assign data_done    = data_done_q;
  assign stallreq_if  = inst_req & ~inst_done_q;
  assign stallreq_mem = data_req & ~data_done_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter
//   Directed bench for sram_port_arbiter: data read, store with delayed ack,
//   simultaneous requests with round-robin, slow fetch, reset in WAIT and a
//   spurious read-valid in IDLE. Inputs change 1 time unit after the rising
//   edge; outputs are sampled at the same point.
module tb_sram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic [31:0] inst_rdata;
  logic        inst_done;
  logic        data_req;
  logic [3:0]  data_wen;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        data_done;
  logic        mem_req;
  logic [3:0]  mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        stallreq_if;
  logic        stallreq_mem;

  int n_chk  = 0;
  int n_pass = 0;

  sram_port_arbiter #(.DATA_FIRST(1'b1)) dut (
    .clk         (clk),
    .rst         (rst),
    .inst_req    (inst_req),
    .inst_addr   (inst_addr),
    .inst_rdata  (inst_rdata),
    .inst_done   (inst_done),
    .data_req    (data_req),
    .data_wen    (data_wen),
    .data_addr   (data_addr),
    .data_wdata  (data_wdata),
    .data_rdata  (data_rdata),
    .data_done   (data_done),
    .mem_req     (mem_req),
    .mem_wen     (mem_wen),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_ack     (mem_ack),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata),
    .stallreq_if (stallreq_if),
    .stallreq_mem(stallreq_mem)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst        = 1'b1;
    inst_req   = 1'b0;
    inst_addr  = 32'd0;
    data_req   = 1'b0;
    data_wen   = 4'd0;
    data_addr  = 32'd0;
    data_wdata = 32'd0;
    mem_ack    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'd0;
    tick();
    tick();
    chk("rst_mem_req",    mem_req,    0);
    chk("rst_mem_wen",    mem_wen,    0);
    chk("rst_mem_addr",   mem_addr,   0);
    chk("rst_mem_wdata",  mem_wdata,  0);
    chk("rst_inst_rdata", inst_rdata, 0);
    chk("rst_data_rdata", data_rdata, 0);
    chk("rst_inst_done",  inst_done,  0);
    chk("rst_data_done",  data_done,  0);
    rst = 1'b0;
    tick();

    // Test 1: data read, minimum latency
    data_req  = 1'b1;
    data_wen  = 4'd0;
    data_addr = 32'h0000_1000;
    #1;
    chk("t1_c1_stallreq_mem", stallreq_mem, 1);
    tick();
    chk("t1_c2_mem_req",      mem_req,      1);
    chk("t1_c2_mem_addr",     mem_addr,     32'h0000_1000);
    chk("t1_c2_mem_wen",      mem_wen,      0);
    chk("t1_c2_stallreq_mem", stallreq_mem, 1);
    mem_ack = 1'b1;
    tick();
    chk("t1_c3_mem_req",      mem_req,      0);
    chk("t1_c3_data_done",    data_done,    0);
    chk("t1_c3_stallreq_mem", stallreq_mem, 1);
    mem_ack    = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hDEAD_BEEF;
    tick();
    chk("t1_c4_data_done",    data_done,    1);
    chk("t1_c4_data_rdata",   data_rdata,   32'hDEAD_BEEF);
    chk("t1_c4_stallreq_mem", stallreq_mem, 0);
    chk("t1_c4_inst_done",    inst_done,    0);
    data_req   = 1'b0;
    mem_rvalid = 1'b0;
    tick();
    chk("t1_c5_data_done",    data_done,    0);

    // Test 2: store, ack delayed two cycles
    data_req   = 1'b1;
    data_wen   = 4'b0011;
    data_addr  = 32'h0000_0010;
    data_wdata = 32'h1234_5678;
    tick();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("t2_addr%0d_mem_req", i),   mem_req,   1);
      chk($sformatf("t2_addr%0d_mem_addr", i),  mem_addr,  32'h0000_0010);
      chk($sformatf("t2_addr%0d_mem_wen", i),   mem_wen,   4'b0011);
      chk($sformatf("t2_addr%0d_mem_wdata", i), mem_wdata, 32'h1234_5678);
      chk($sformatf("t2_addr%0d_data_done", i), data_done, 0);
      // Fields changed mid-request must not reach the port.
      if (i == 0) data_addr = 32'h0000_0044;
      if (i == 2) mem_ack = 1'b1;
      tick();
    end
    chk("t2_c5_data_done",  data_done,  1);
    chk("t2_c5_mem_req",    mem_req,    0);
    chk("t2_c5_data_rdata", data_rdata, 32'hDEAD_BEEF);
    data_req   = 1'b0;
    data_wen   = 4'd0;
    data_wdata = 32'd0;
    mem_ack    = 1'b0;
    tick();
    chk("t2_c6_data_done",  data_done,  0);

    // Test 3: simultaneous requests after reset, data wins first
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    inst_req  = 1'b1;
    inst_addr = 32'hBFC0_0000;
    data_req  = 1'b1;
    data_wen  = 4'd0;
    data_addr = 32'h0000_0020;
    #1;
    chk("t3_c1_stallreq_if",  stallreq_if,  1);
    chk("t3_c1_stallreq_mem", stallreq_mem, 1);
    tick();
    chk("t3_addr_mem_addr",   mem_addr,     32'h0000_0020);
    chk("t3_addr_stallreq_if", stallreq_if, 1);
    mem_ack = 1'b1;
    tick();
    chk("t3_wait_stallreq_if", stallreq_if, 1);
    mem_ack    = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hA5A5_0020;
    tick();
    chk("t3_done_data_done",   data_done,   1);
    chk("t3_done_data_rdata",  data_rdata,  32'hA5A5_0020);
    chk("t3_done_inst_done",   inst_done,   0);
    chk("t3_done_stallreq_if", stallreq_if, 1);
    // Data immediately presents a new read: repeated tie, inst must win.
    data_addr  = 32'h0000_0024;
    mem_rvalid = 1'b0;
    tick();
    chk("t3_idle_mem_req",      mem_req,      0);
    chk("t3_idle_stallreq_if",  stallreq_if,  1);
    chk("t3_idle_stallreq_mem", stallreq_mem, 1);
    tick();
    chk("t3_tie_mem_addr",  mem_addr,  32'hBFC0_0000);
    chk("t3_tie_mem_wen",   mem_wen,   0);
    chk("t3_tie_mem_wdata", mem_wdata, 0);
    chk("t3_tie_mem_req",   mem_req,   1);

    // Test 4: fetch with slow read return
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t4_wait%0d_mem_req", i),     mem_req,     0);
      chk($sformatf("t4_wait%0d_inst_done", i),   inst_done,   0);
      chk($sformatf("t4_wait%0d_stallreq_if", i), stallreq_if, 1);
      if (i == 4) begin
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h2402_0001;
      end
      tick();
    end
    chk("t4_done_inst_done",   inst_done,   1);
    chk("t4_done_inst_rdata",  inst_rdata,  32'h2402_0001);
    chk("t4_done_data_rdata",  data_rdata,  32'hA5A5_0020);
    chk("t4_done_data_done",   data_done,   0);
    chk("t4_done_stallreq_if", stallreq_if, 0);
    inst_req   = 1'b0;
    mem_rvalid = 1'b0;
    tick();
    chk("t4_after_inst_done", inst_done, 0);
    tick();
    // Pending data read is served right after the single foreign transaction.
    chk("t4_data_mem_addr", mem_addr, 32'h0000_0024);
    chk("t4_data_mem_req",  mem_req,  1);

    // Test 5: reset while in WAIT
    mem_ack = 1'b1;
    tick();
    chk("t5_wait_mem_req", mem_req, 0);
    mem_ack = 1'b0;
    rst     = 1'b1;
    tick();
    chk("t5_rst_mem_req",    mem_req,    0);
    chk("t5_rst_mem_addr",   mem_addr,   0);
    chk("t5_rst_data_done",  data_done,  0);
    chk("t5_rst_inst_done",  inst_done,  0);
    chk("t5_rst_inst_rdata", inst_rdata, 0);
    chk("t5_rst_data_rdata", data_rdata, 0);
    rst        = 1'b0;
    data_req   = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hFFFF_FFFF;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk($sformatf("t5_late%0d_data_done", i),  data_done,  0);
      chk($sformatf("t5_late%0d_inst_done", i),  inst_done,  0);
      chk($sformatf("t5_late%0d_data_rdata", i), data_rdata, 0);
      chk($sformatf("t5_late%0d_inst_rdata", i), inst_rdata, 0);
      chk($sformatf("t5_late%0d_mem_req", i),    mem_req,    0);
    end
    mem_rvalid = 1'b0;

    // Test 6: spurious read-valid while IDLE
    data_req  = 1'b1;
    data_wen  = 4'd0;
    data_addr = 32'h0000_0030;
    tick();
    mem_ack = 1'b1;
    tick();
    mem_ack    = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hCAFE_F00D;
    tick();
    chk("t6_done_data_done",  data_done,  1);
    chk("t6_done_data_rdata", data_rdata, 32'hCAFE_F00D);
    data_req   = 1'b0;
    mem_rvalid = 1'b0;
    tick();
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h0BAD_0BAD;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk($sformatf("t6_idle%0d_data_done", i),  data_done,  0);
      chk($sformatf("t6_idle%0d_inst_done", i),  inst_done,  0);
      chk($sformatf("t6_idle%0d_data_rdata", i), data_rdata, 32'hCAFE_F00D);
      chk($sformatf("t6_idle%0d_inst_rdata", i), inst_rdata, 0);
      chk($sformatf("t6_idle%0d_mem_req", i),    mem_req,    0);
    end
    mem_rvalid = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
